// File: rtl/multicycle_control_unit_pkg.sv
// Shared types for the multi-cycle RV32I control unit.
//  fsm_state    : control FSM states (FAULT is absorbing until reset)
//  alu_ctrl     : ALU operation select
//  instr_format : immediate-generator format select
//  result_src   : writeback mux select
//  Opcode and branch funct3 constants, plus an opcode legality helper.
package multicycle_control_unit_pkg;

  typedef enum logic [2:0] {
    FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, FAULT
  } fsm_state;

  typedef enum logic [3:0] {
    SUM_OP, SUB_OP, AND_OP, OR_OP, XOR_OP, SLL_OP, SRL_OP, SRA_OP, SLT_OP, SLTU_OP
  } alu_ctrl;

  typedef enum logic [1:0] {Imm, Store, Branch, Jump} instr_format;

  typedef enum logic [1:0] {RES_ALU, RES_MEM, RES_PC4} result_src;

  localparam logic [6:0] R_TYPE = 7'b0110011;
  localparam logic [6:0] I_ALU  = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;
  localparam logic [2:0] F3_BLT = 3'b100;
  localparam logic [2:0] F3_BGE = 3'b101;

  function automatic logic is_legal_opcode(input logic [6:0] op);
    case (op)
      R_TYPE, I_ALU, LOAD, STORE, BRANCH, JAL: return 1'b1;
      default:                                 return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Bus between the control unit (master) and the datapath/memory side (slave).
//  Inputs to the control unit : instr, EQ, LT, mem_ready, stall
//  Outputs of the control unit: datapath enables/selects, instr_retired, fault,
//                               and state (FSM debug view).
// Memory handshake: MemRead/MemWrite act as the request (valid) and stay high
// until the memory answers with a one-cycle mem_ready; the transfer completes on
// the cycle both are high while stall is low. A mem_ready seen during stall is
// dropped and must be presented again.
interface multicycle_control_unit_if #(
  parameter int DATA_WIDTH = 32
);
  import multicycle_control_unit_pkg::*;

  logic [DATA_WIDTH-1:0] instr;
  logic                  EQ;
  logic                  LT;
  logic                  mem_ready;
  logic                  stall;

  logic                  RegWrite;
  alu_ctrl               ALUctrl;
  logic                  ALUsrc;
  instr_format           ImmSrc;
  logic                  PCsrc;
  logic                  PCwrite;
  logic                  IRwrite;
  logic                  MemRead;
  logic                  MemWrite;
  logic                  IorD;
  result_src             ResultSrc;
  logic                  instr_retired;
  logic                  fault;
  fsm_state              state;

  modport master (
    input  instr, EQ, LT, mem_ready, stall,
    output RegWrite, ALUctrl, ALUsrc, ImmSrc, PCsrc, PCwrite, IRwrite,
           MemRead, MemWrite, IorD, ResultSrc, instr_retired, fault, state
  );

  modport slave (
    output instr, EQ, LT, mem_ready, stall,
    input  RegWrite, ALUctrl, ALUsrc, ImmSrc, PCsrc, PCwrite, IRwrite,
           MemRead, MemWrite, IorD, ResultSrc, instr_retired, fault, state
  );

endinterface

// File: rtl/multicycle_control_unit_alu_decoder.sv
// Combinational ALU operation decoder.
//  opcode, funct3, funct7_5 (instr[30]) -> alu_op
// Branches compare by subtraction; loads, stores and jal use SUM_OP for
// address/target arithmetic.
module multicycle_control_unit_alu_decoder
  import multicycle_control_unit_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  output alu_ctrl    alu_op
);

  always_comb begin
    alu_op = SUM_OP;
    case (opcode)
      BRANCH: alu_op = SUB_OP;
      R_TYPE, I_ALU: begin
        case (funct3)
          // instr[30] is part of the immediate for addi, so only R-type subtracts
          3'b000:  alu_op = (opcode == R_TYPE && funct7_5) ? SUB_OP : SUM_OP;
          3'b001:  alu_op = SLL_OP;
          3'b010:  alu_op = SLT_OP;
          3'b011:  alu_op = SLTU_OP;
          3'b100:  alu_op = XOR_OP;
          3'b101:  alu_op = funct7_5 ? SRA_OP : SRL_OP;
          3'b110:  alu_op = OR_OP;
          default: alu_op = AND_OP;
        endcase
      end
      default: alu_op = SUM_OP;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle FSM control unit for the RV32I core.
//  clk, rst : clock, synchronous active-high reset
//  bus      : multicycle_control_unit_if.master (instruction/flags/handshake in,
//             datapath enables, retire pulse, sticky fault and state out)
// Sequences FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK. Only state, wait_cnt and
// fault are registers; every other output is decoded from them plus inputs.
module multicycle_control_unit
  import multicycle_control_unit_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int MEM_WAIT_MAX = 8
) (
  input logic                     clk,
  input logic                     rst,
  multicycle_control_unit_if.master bus
);

  localparam int CNT_W = $clog2(MEM_WAIT_MAX + 1);

  fsm_state              state;
  logic [CNT_W-1:0]      wait_cnt;
  logic                  fault_q;

  logic [DATA_WIDTH-1:0] ir;
  logic [6:0]            opcode;
  logic [2:0]            funct3;
  alu_ctrl               dec_alu;
  logic                  mem_state;
  logic                  mem_done;
  logic                  timeout;
  logic                  taken;
  logic [CNT_W-1:0]      cnt_inc;
  logic                  unused_ir_bits;

  assign ir             = bus.instr;
  assign opcode         = ir[6:0];
  assign funct3         = ir[14:12];
  assign unused_ir_bits = ^{ir[DATA_WIDTH-1:31], ir[29:15], ir[11:7]};

  multicycle_control_unit_alu_decoder u_alu_decoder (
    .opcode   (opcode),
    .funct3   (funct3),
    .funct7_5 (ir[30]),
    .alu_op   (dec_alu)
  );

  assign mem_state = (state == FETCH) || (state == MEMORY);
  assign mem_done  = mem_state && bus.mem_ready && !bus.stall;
  assign cnt_inc   = wait_cnt + CNT_W'(1);
  // The MEM_WAIT_MAX-th waiting cycle without mem_ready is the last chance;
  // a mem_ready on that cycle still completes normally.
  assign timeout   = mem_state && !bus.mem_ready && !bus.stall &&
                     (cnt_inc == CNT_W'(MEM_WAIT_MAX));

  always_comb begin
    case (funct3)
      F3_BEQ:  taken = bus.EQ;
      F3_BNE:  taken = !bus.EQ;
      F3_BLT:  taken = bus.LT;
      F3_BGE:  taken = !bus.LT;
      default: taken = 1'b0;  // bltu/bgeu have no unsigned flag here: never taken
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FETCH;
      wait_cnt <= '0;
      fault_q  <= 1'b0;
    end else if (!bus.stall) begin
      case (state)
        FETCH: begin
          if (bus.mem_ready)  state <= DECODE;
          else if (timeout)   state <= FAULT;
        end
        DECODE:    state <= is_legal_opcode(opcode) ? EXECUTE : FAULT;
        EXECUTE: begin
          case (opcode)
            LOAD, STORE: state <= MEMORY;
            BRANCH:      state <= FETCH;
            default:     state <= WRITEBACK;
          endcase
        end
        MEMORY: begin
          if (bus.mem_ready)  state <= (opcode == LOAD) ? WRITEBACK : FETCH;
          else if (timeout)   state <= FAULT;
        end
        WRITEBACK: state <= FETCH;
        default:   state <= FAULT;
      endcase
      // Any completion or state change restarts the wait count.
      wait_cnt <= (mem_state && !bus.mem_ready && !timeout) ? cnt_inc : '0;
      if (timeout || (state == DECODE && !is_legal_opcode(opcode))) fault_q <= 1'b1;
    end
  end

  always_comb begin
    bus.RegWrite      = 1'b0;
    bus.ALUctrl       = SUM_OP;
    bus.ALUsrc        = 1'b0;
    bus.ImmSrc        = Imm;
    bus.PCsrc         = 1'b0;
    bus.PCwrite       = 1'b0;
    bus.IRwrite       = 1'b0;
    bus.MemRead       = 1'b0;
    bus.MemWrite      = 1'b0;
    bus.IorD          = 1'b0;
    bus.ResultSrc     = RES_ALU;
    bus.instr_retired = 1'b0;
    case (state)
      FETCH: begin
        bus.MemRead = 1'b1;
        bus.IRwrite = mem_done;
        bus.PCwrite = mem_done;  // PC+4, datapath captures OldPC alongside IR
      end
      EXECUTE: begin
        bus.ALUctrl = dec_alu;
        case (opcode)
          I_ALU, LOAD: bus.ALUsrc = 1'b1;
          STORE: begin
            bus.ALUsrc = 1'b1;
            bus.ImmSrc = Store;
          end
          BRANCH: begin
            bus.ImmSrc        = Branch;
            bus.PCsrc         = taken;
            bus.PCwrite       = taken && !bus.stall;
            bus.instr_retired = !bus.stall;
          end
          JAL: begin
            bus.ALUsrc  = 1'b1;
            bus.ImmSrc  = Jump;
            bus.PCsrc   = 1'b1;
            bus.PCwrite = !bus.stall;
          end
          default: bus.ALUsrc = 1'b0;
        endcase
      end
      MEMORY: begin
        bus.IorD          = 1'b1;
        bus.MemRead       = (opcode == LOAD);
        bus.MemWrite      = (opcode == STORE) && !bus.stall;
        bus.instr_retired = mem_done && (opcode == STORE);
      end
      WRITEBACK: begin
        bus.RegWrite      = !bus.stall;
        bus.instr_retired = !bus.stall;
        if (opcode == LOAD)     bus.ResultSrc = RES_MEM;
        else if (opcode == JAL) bus.ResultSrc = RES_PC4;
        else                    bus.ResultSrc = RES_ALU;
      end
      default: ;
    endcase
  end

  assign bus.fault = fault_q;
  assign bus.state = state;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit (MEM_WAIT_MAX = 4).
// Each cycle's inputs and expected outputs are queued together; run() drains
// the queues one clock at a time and compares the observed output vector.
module tb_multicycle_control_unit;
  import multicycle_control_unit_pkg::*;

  localparam int W = 21;  // state(3) + flags(10) + ImmSrc(2) + ResultSrc(2) + ALUctrl(4)

  // flag bit positions inside the 10-bit flag field
  localparam logic [9:0] F_NONE = 10'b0000000000;
  localparam logic [9:0] F_RW   = 10'b1000000000;
  localparam logic [9:0] F_ASRC = 10'b0100000000;
  localparam logic [9:0] F_PCS  = 10'b0010000000;
  localparam logic [9:0] F_PCW  = 10'b0001000000;
  localparam logic [9:0] F_IRW  = 10'b0000100000;
  localparam logic [9:0] F_MR   = 10'b0000010000;
  localparam logic [9:0] F_MW   = 10'b0000001000;
  localparam logic [9:0] F_IORD = 10'b0000000100;
  localparam logic [9:0] F_RET  = 10'b0000000010;
  localparam logic [9:0] F_FLT  = 10'b0000000001;

  // stimulus bits {rst, mem_ready, stall, EQ, LT}
  localparam logic [4:0] S_NONE  = 5'b00000;
  localparam logic [4:0] S_RST   = 5'b10000;
  localparam logic [4:0] S_RDY   = 5'b01000;
  localparam logic [4:0] S_STALL = 5'b00100;
  localparam logic [4:0] S_EQ    = 5'b00010;
  localparam logic [4:0] S_LT    = 5'b00001;

  logic clk;
  logic rst;

  multicycle_control_unit_if #(.DATA_WIDTH(32)) bus ();

  multicycle_control_unit #(.DATA_WIDTH(32), .MEM_WAIT_MAX(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [4:0]   stim_q[$];
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  function automatic logic [W-1:0] mk(input fsm_state st, input logic [9:0] f,
                                      input instr_format imm, input result_src res,
                                      input alu_ctrl alu);
    return {st, f, imm, res, alu};
  endfunction

  task automatic add(input logic [4:0] s, input logic [W-1:0] e);
    stim_q.push_back(s);
    exp_q.push_back(e);
  endtask

  // FETCH with memory answering at once
  task automatic add_fetch_decode();
    add(S_RDY, mk(FETCH, F_MR | F_IRW | F_PCW, Imm, RES_ALU, SUM_OP));
    add(S_RDY, mk(DECODE, F_NONE, Imm, RES_ALU, SUM_OP));
  endtask

  task automatic run(input string name);
    logic [4:0]   s;
    logic [W-1:0] e;
    logic [W-1:0] o;
    int idx;
    idx = 0;
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      {rst, bus.mem_ready, bus.stall, bus.EQ, bus.LT} = s;
      #1;
      e = exp_q.pop_front();
      o = mk(bus.state,
             {bus.RegWrite, bus.ALUsrc, bus.PCsrc, bus.PCwrite, bus.IRwrite,
              bus.MemRead, bus.MemWrite, bus.IorD, bus.instr_retired, bus.fault},
             bus.ImmSrc, bus.ResultSrc, bus.ALUctrl);
      n_checks++;
      assert (o === e) n_pass++;
      else $error("FAIL %s[%0d] observed=%h expected=%h", name, idx, o, e);
      idx++;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL time_limit observed=running required=finished");
    $fatal(1, "time limit");
  end

  initial begin
    rst           = 1'b1;
    bus.instr     = 32'h0000_0000;
    bus.EQ        = 1'b0;
    bus.LT        = 1'b0;
    bus.mem_ready = 1'b0;
    bus.stall     = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // reset state: FETCH, only the fetch read request, no fault
    add(S_NONE, mk(FETCH, F_MR, Imm, RES_ALU, SUM_OP));
    run("reset");

    // addi x1,x0,5
    bus.instr = 32'h0050_0093;
    add_fetch_decode();
    add(S_RDY, mk(EXECUTE, F_ASRC, Imm, RES_ALU, SUM_OP));
    add(S_RDY, mk(WRITEBACK, F_RW | F_RET, Imm, RES_ALU, SUM_OP));
    run("addi");

    // bne taken (EQ=0) and not taken (EQ=1)
    bus.instr = 32'h0020_9463;
    add_fetch_decode();
    add(S_RDY, mk(EXECUTE, F_PCW | F_PCS | F_RET, Branch, RES_ALU, SUB_OP));
    run("bne_taken");
    add_fetch_decode();
    add(S_RDY | S_EQ, mk(EXECUTE, F_RET, Branch, RES_ALU, SUB_OP));
    run("bne_not_taken");

    // blt taken on LT=1
    bus.instr = 32'h0020_C463;
    add_fetch_decode();
    add(S_RDY | S_LT, mk(EXECUTE, F_PCW | F_PCS | F_RET, Branch, RES_ALU, SUB_OP));
    run("blt_taken");

    // lw, mem_ready three cycles late: ready lands on the last allowed cycle
    bus.instr = 32'h0000_A183;
    add_fetch_decode();
    add(S_NONE, mk(EXECUTE, F_ASRC, Imm, RES_ALU, SUM_OP));
    repeat (3) add(S_NONE, mk(MEMORY, F_MR | F_IORD, Imm, RES_ALU, SUM_OP));
    add(S_RDY, mk(MEMORY, F_MR | F_IORD, Imm, RES_ALU, SUM_OP));
    add(S_NONE, mk(WRITEBACK, F_RW | F_RET, Imm, RES_MEM, SUM_OP));
    run("lw_late");

    // sw with a stall while memory is ready: write masked, completion ignored
    bus.instr = 32'h0020_A023;
    add_fetch_decode();
    add(S_NONE, mk(EXECUTE, F_ASRC, Store, RES_ALU, SUM_OP));
    add(S_RDY | S_STALL, mk(MEMORY, F_IORD, Imm, RES_ALU, SUM_OP));
    add(S_RDY, mk(MEMORY, F_MW | F_IORD | F_RET, Imm, RES_ALU, SUM_OP));
    run("sw_stall");

    // jal x1,8
    bus.instr = 32'h0080_00EF;
    add_fetch_decode();
    add(S_NONE, mk(EXECUTE, F_ASRC | F_PCW | F_PCS, Jump, RES_ALU, SUM_OP));
    add(S_NONE, mk(WRITEBACK, F_RW | F_RET, Imm, RES_PC4, SUM_OP));
    run("jal");

    // srai x1,x1,3
    bus.instr = 32'h4030_D093;
    add_fetch_decode();
    add(S_NONE, mk(EXECUTE, F_ASRC, Imm, RES_ALU, SRA_OP));
    add(S_NONE, mk(WRITEBACK, F_RW | F_RET, Imm, RES_ALU, SUM_OP));
    run("srai");

    // sub x3,x1,x2 with a fetch stall and a two-cycle writeback stall
    bus.instr = 32'h4020_81B3;
    add(S_RDY | S_STALL, mk(FETCH, F_MR, Imm, RES_ALU, SUM_OP));
    add_fetch_decode();
    add(S_NONE, mk(EXECUTE, F_NONE, Imm, RES_ALU, SUB_OP));
    repeat (2) add(S_STALL, mk(WRITEBACK, F_NONE, Imm, RES_ALU, SUM_OP));
    add(S_NONE, mk(WRITEBACK, F_RW | F_RET, Imm, RES_ALU, SUM_OP));
    run("sub_stall");

    // illegal opcode 0x7F faults out of DECODE; fault is sticky
    bus.instr = 32'h0000_007F;
    add_fetch_decode();
    repeat (3) add(S_RDY, mk(FAULT, F_FLT, Imm, RES_ALU, SUM_OP));
    run("illegal");

    // reset out of FAULT, then fetch timeout after MEM_WAIT_MAX cycles
    bus.instr = 32'h0050_0093;
    add(S_RST, mk(FAULT, F_FLT, Imm, RES_ALU, SUM_OP));
    repeat (4) add(S_NONE, mk(FETCH, F_MR, Imm, RES_ALU, SUM_OP));
    repeat (2) add(S_RDY, mk(FAULT, F_FLT, Imm, RES_ALU, SUM_OP));
    run("timeout");

    // reset in the middle of a store's MEMORY phase
    bus.instr = 32'h0020_A023;
    add(S_RST, mk(FAULT, F_FLT, Imm, RES_ALU, SUM_OP));
    add_fetch_decode();
    add(S_NONE, mk(EXECUTE, F_ASRC, Store, RES_ALU, SUM_OP));
    add(S_NONE, mk(MEMORY, F_MW | F_IORD, Imm, RES_ALU, SUM_OP));
    add(S_RST, mk(MEMORY, F_MW | F_IORD, Imm, RES_ALU, SUM_OP));
    add(S_NONE, mk(FETCH, F_MR, Imm, RES_ALU, SUM_OP));
    run("rst_mid_mem");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
